// File: rtl/p_to_s_pkg.sv
// Shared types and helpers for the parallel-to-serial frame converter.
package p_to_s_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    // Occupancy of one frame slot: empty, or holding a frame with beats still to send.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } slot_state_e;

    // True when the beat counter sits on the final beat of a frame.
    function automatic logic is_last_beat(input cnt_t cnt, input int unsigned nb_beats);
        return cnt == cnt_t'(nb_beats - 1);
    endfunction

endpackage

// File: rtl/p_to_s_frame_slot.sv
// One frame register with its occupancy state. Load wins over clear so that a
// slot can be emptied and refilled on the same edge.
module p_to_s_frame_slot
    import p_to_s_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 load,
    input  logic                                 clear,
    input  logic [0:NUM_WORDS-1][WORD_WIDTH-1:0] din,
    output logic [0:NUM_WORDS-1][WORD_WIDTH-1:0] dout,
    output slot_state_e                          state
);

    logic [0:NUM_WORDS-1][WORD_WIDTH-1:0] data_q;
    slot_state_e                          state_q;

    // Capture the frame and track whether the slot is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            state_q <= IDLE;
        end else if (load) begin
            data_q  <= din;
            state_q <= SEND;
        end else if (clear) begin
            state_q <= IDLE;
        end
    end

    assign dout  = data_q;
    assign state = state_q;

endmodule

// File: rtl/p_to_s_converter.sv
// Parallel-to-serial converter: accepts PARALLEL_LENGTH-word frames and emits
// them as NB_BEATS beats of SERIAL_LENGTH words, word 0 first. Two frame slots
// (ACTIVE being serialised, PENDING waiting) let frames stream back-to-back
// with no idle cycle between the last beat of one frame and beat 0 of the next.
// PARALLEL_LENGTH must be an integer multiple of SERIAL_LENGTH.
module p_to_s_converter
    import p_to_s_pkg::*;
#(
    parameter int unsigned SERIAL_LENGTH   = 1,
    parameter int unsigned PARALLEL_LENGTH = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       ien,
    input  logic [0:PARALLEL_LENGTH-1][WORD_WIDTH-1:0] idata,
    output logic                                       ready,
    input  logic                                       fct,
    output logic                                       oen,
    output logic [0:SERIAL_LENGTH-1][WORD_WIDTH-1:0]   odata,
    output logic                                       olast
);

    localparam int unsigned NB_BEATS = PARALLEL_LENGTH / SERIAL_LENGTH;

    typedef logic [0:PARALLEL_LENGTH-1][WORD_WIDTH-1:0] frame_t;
    typedef logic [0:SERIAL_LENGTH-1][WORD_WIDTH-1:0]   beat_t;

    // Slot interfaces
    frame_t      act_data;
    frame_t      pend_data;
    frame_t      act_din;
    slot_state_e act_state;
    slot_state_e pend_state;
    logic        act_valid;
    logic        pend_valid;
    logic        act_load;
    logic        act_clear;
    logic        pend_load;
    logic        pend_clear;

    // Control
    logic        rst_done_q;
    logic        accept;
    logic        emit;
    logic        last_beat;
    logic        act_free;

    // Beat path
    cnt_t        cnt_q;
    beat_t       beat_words;
    beat_t       odata_q;
    logic        oen_q;
    logic        olast_q;

    assign act_valid  = (act_state == SEND);
    assign pend_valid = (pend_state == SEND);

    // Held low through reset and for the edge that ends it, so ready only
    // depends on registered state and never on ien.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    assign ready = rst_done_q & ~pend_valid;

    // Slot steering: the ACTIVE slot is free on this edge when it is empty or
    // sending its final beat. A waiting PENDING frame always takes priority; a
    // new frame can only arrive while PENDING is empty, so the two never clash.
    always_comb begin
        accept     = ien & ready;
        emit       = act_valid & ~fct;
        last_beat  = emit & is_last_beat(cnt_q, NB_BEATS);
        act_free   = ~act_valid | last_beat;

        act_load   = act_free & (pend_valid | accept);
        act_din    = pend_valid ? pend_data : idata;
        act_clear  = last_beat;

        pend_load  = accept & ~act_free;
        pend_clear = act_free & pend_valid;
    end

    p_to_s_frame_slot #(
        .NUM_WORDS (PARALLEL_LENGTH)
    ) u_active (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (act_load),
        .clear (act_clear),
        .din   (act_din),
        .dout  (act_data),
        .state (act_state)
    );

    p_to_s_frame_slot #(
        .NUM_WORDS (PARALLEL_LENGTH)
    ) u_pending (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pend_load),
        .clear (pend_clear),
        .din   (idata),
        .dout  (pend_data),
        .state (pend_state)
    );

    // Select the words of the current beat from the ACTIVE frame.
    always_comb begin
        beat_words = '0;
        for (int unsigned b = 0; b < NB_BEATS; b++) begin
            if (cnt_q == cnt_t'(b)) begin
                for (int unsigned w = 0; w < SERIAL_LENGTH; w++) begin
                    beat_words[w] = act_data[b * SERIAL_LENGTH + w];
                end
            end
        end
    end

    // Register the beat outputs and advance the beat counter; a stall holds
    // odata and the counter but drops oen/olast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            odata_q <= '0;
            oen_q   <= 1'b0;
            olast_q <= 1'b0;
        end else if (emit) begin
            odata_q <= beat_words;
            oen_q   <= 1'b1;
            olast_q <= last_beat;
            cnt_q   <= last_beat ? '0 : cnt_q + cnt_t'(1);
        end else begin
            oen_q   <= 1'b0;
            olast_q <= 1'b0;
        end
    end

    assign oen   = oen_q;
    assign odata = odata_q;
    assign olast = olast_q;

endmodule
